// File: rtl/hazard_controller.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush and memory wait.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_COUNTERS_EN.
module hazard_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rs1D,
  input  logic [3:0] rs2D,
  input  logic [3:0] rs1E,
  input  logic [3:0] rs2E,
  input  logic [3:0] rdE,
  input  logic [3:0] rdM,
  input  logic [3:0] rdW,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic [1:0] resultSrcE,
  input  logic       pcSrcE,
  input  logic       memBusyM,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic       stallE,
  output logic       stallM,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  state_t state, state_next;
  logic   load_use;

  // Memory-stage result is newer than writeback, so it wins when both match.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regWriteM && (rdM == rs1E))      forwardAE = 2'b10;
    else if (regWriteW && (rdW == rs1E)) forwardAE = 2'b01;
    if (regWriteM && (rdM == rs2E))      forwardBE = 2'b10;
    else if (regWriteW && (rdW == rs2E)) forwardBE = 2'b01;
  end

  assign load_use = (resultSrcE == 2'b01) && regWriteE &&
                    ((rdE == rs1D) || (rdE == rs2D));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // MEM_WAIT releases into a normal RUN evaluation; only LOAD_STALL suppresses the hazard check.
  always_comb begin
    stallF     = 1'b0;
    stallD     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    state_next = RUN;
    if (!rst) begin
      if (memBusyM) begin
        stallF     = 1'b1;
        stallD     = 1'b1;
        stallE     = 1'b1;
        stallM     = 1'b1;
        state_next = MEM_WAIT;
      end else if (pcSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if ((state != LOAD_STALL) && load_use) begin
        stallF     = 1'b1;
        stallD     = 1'b1;
        flushE     = 1'b1;
        state_next = LOAD_STALL;
      end
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [15:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (stallF && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flushE && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign stallCount = stall_cnt;
  assign flushCount = flush_cnt;
`else
  assign stallCount = 16'h0000;
  assign flushCount = 16'h0000;
`endif

endmodule
